// File: rtl/checkout_total_if.sv
// Transaction bus between the till front end and the checkout_total stage.
// The master side drives item entry, checkout, payment and cancel; the
// slave side (checkout_total) returns the registered bill status.
interface checkout_total_if #(
  parameter int TOTAL_W = 12
) ();
  logic               item_valid;
  logic [7:0]         cur_unit_price;
  logic               checkout;
  logic               pay_valid;
  logic [TOTAL_W-1:0] pay;
  logic               cancel;
  logic [TOTAL_W-1:0] total;
  logic [3:0]         item_count;
  logic [TOTAL_W-1:0] change;
  logic               done;
  logic               short_pay;
  logic               item_full;
  logic               overflow;
  logic               busy;

  modport master (
    output item_valid, cur_unit_price, checkout, pay_valid, pay, cancel,
    input  total, item_count, change, done, short_pay, item_full, overflow, busy
  );

  modport slave (
    input  item_valid, cur_unit_price, checkout, pay_valid, pay, cancel,
    output total, item_count, change, done, short_pay, item_full, overflow, busy
  );
endinterface

// File: rtl/checkout_total.sv
// Running bill accumulator for one register transaction: sums item
// subtotals with saturation, counts items up to MAX_ITEMS, then accepts a
// payment and reports change or a short payment. All outputs registered.
module checkout_total #(
  parameter int TOTAL_W   = 12,
  parameter int MAX_ITEMS = 15
) (
  input logic             clk,
  input logic             rst,
  checkout_total_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_PAY, DONE} state_t;

  localparam logic [TOTAL_W-1:0] MAX_TOTAL = '1;
  localparam logic [3:0]         MAX_CNT   = 4'(MAX_ITEMS);

  state_t             state_p0, state_p1;
  logic [TOTAL_W-1:0] total_p0, total_p1;
  logic [3:0]         count_p0, count_p1;
  logic [TOTAL_W-1:0] change_p0, change_p1;
  logic               done_p0, done_p1;
  logic               short_p0, short_p1;
  logic               full_p0, full_p1;
  logic               ovf_p0, ovf_p1;
  logic               busy_p0, busy_p1;
  logic [TOTAL_W:0]   acc_sum;
  logic [TOTAL_W-1:0] price_ext;

  // Saturating add; the MSB of the result flags that the sum was clamped.
  function automatic logic [TOTAL_W:0] sat_add(input logic [TOTAL_W-1:0] a,
                                               input logic [TOTAL_W-1:0] b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[TOTAL_W]) return {1'b1, MAX_TOTAL};
    return s;
  endfunction

  assign price_ext = TOTAL_W'(bus.cur_unit_price);
  assign acc_sum   = sat_add(total_p1, price_ext);

  // Transaction state register.
  always_ff @(posedge clk) begin
    if (rst) state_p1 <= IDLE;
    else     state_p1 <= state_p0;
  end

  // Next-state decode; cancel overrides every other request.
  always_comb begin
    state_p0 = state_p1;
    if (bus.cancel) begin
      state_p0 = IDLE;
    end else begin
      unique case (state_p1)
        IDLE:     if (bus.item_valid) state_p0 = ACCUM;
        ACCUM:    if (bus.checkout) state_p0 = WAIT_PAY;
        WAIT_PAY: if (bus.pay_valid && (bus.pay >= total_p1)) state_p0 = DONE;
        DONE:     if (bus.item_valid) state_p0 = ACCUM;
        default:  state_p0 = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs for the coming edge.
  always_comb begin
    total_p0  = total_p1;
    count_p0  = count_p1;
    change_p0 = change_p1;
    done_p0   = done_p1;
    ovf_p0    = ovf_p1;
    short_p0  = 1'b0;
    if (bus.cancel) begin
      total_p0  = '0;
      count_p0  = '0;
      change_p0 = '0;
      done_p0   = 1'b0;
      ovf_p0    = 1'b0;
    end else begin
      unique case (state_p1)
        IDLE, DONE: begin
          if (bus.item_valid) begin
            total_p0  = price_ext;
            count_p0  = 4'd1;
            change_p0 = '0;
            done_p0   = 1'b0;
            ovf_p0    = 1'b0;
          end
        end
        ACCUM: begin
          // A full transaction silently drops further items.
          if (bus.item_valid && (count_p1 < MAX_CNT)) begin
            total_p0 = acc_sum[TOTAL_W-1:0];
            ovf_p0   = ovf_p1 | acc_sum[TOTAL_W];
            count_p0 = count_p1 + 4'd1;
          end
        end
        WAIT_PAY: begin
          if (bus.pay_valid) begin
            if (bus.pay >= total_p1) begin
              change_p0 = bus.pay - total_p1;
              done_p0   = 1'b1;
            end else begin
              short_p0 = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    full_p0 = (count_p0 == MAX_CNT);
    busy_p0 = (state_p0 == ACCUM) || (state_p0 == WAIT_PAY);
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_p1  <= '0;
      count_p1  <= '0;
      change_p1 <= '0;
      done_p1   <= 1'b0;
      short_p1  <= 1'b0;
      full_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
      busy_p1   <= 1'b0;
    end else begin
      total_p1  <= total_p0;
      count_p1  <= count_p0;
      change_p1 <= change_p0;
      done_p1   <= done_p0;
      short_p1  <= short_p0;
      full_p1   <= full_p0;
      ovf_p1    <= ovf_p0;
      busy_p1   <= busy_p0;
    end
  end

  assign bus.total      = total_p1;
  assign bus.item_count = count_p1;
  assign bus.change     = change_p1;
  assign bus.done       = done_p1;
  assign bus.short_pay  = short_p1;
  assign bus.item_full  = full_p1;
  assign bus.overflow   = ovf_p1;
  assign bus.busy       = busy_p1;

endmodule
